// File: rtl/matrix_input_parser.sv
// Parses "m n e0 e1 ..." ASCII matrix entries from a UART byte stream and hands the
// dimensions plus the elements (zero padded to m*n) to the matrix storage block.
module matrix_input_parser #(
  parameter int ELEM_WIDTH   = 8,
  parameter int MAX_DIM      = 5,
  parameter int DONE_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  input  logic                  input_done,
  output logic                  wen,
  output logic [3:0]            m,
  output logic [3:0]            n,
  output logic [ELEM_WIDTH-1:0] elem_in,
  output logic                  elem_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [1:0]            err_code
);
  localparam int TMO_W = $clog2(DONE_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, GET_M, GET_N, ELEMS, PAD, WAIT_DONE} state_t;

  state_t           state;
  logic [7:0]       acc;
  logic [7:0]       m_tok;
  logic             have_digit;
  logic             done_seen;
  logic [4:0]       cnt;
  logic [TMO_W-1:0] tmo;

  logic        is_digit, is_sep, is_term, commit, take, dims_ok;
  logic [11:0] acc_mul;
  logic [7:0]  acc_sat;
  logic [4:0]  total, cnt_after;

  // Byte classification and the token value a separator/terminator would commit.
  always_comb begin
    is_digit  = rx_valid && (rx_data >= 8'h30) && (rx_data <= 8'h39);
    is_sep    = rx_valid && ((rx_data == 8'h20) || (rx_data == 8'h2C));
    is_term   = rx_valid && ((rx_data == 8'h0D) || (rx_data == 8'h0A));
    commit    = (is_sep || is_term) && have_digit;
    acc_mul   = ({4'd0, acc} * 12'd10) + {8'd0, rx_data[3:0]};
    acc_sat   = (acc_mul > 12'd255) ? 8'hFF : acc_mul[7:0];
    total     = {1'b0, m} * {1'b0, n};
    take      = commit && (cnt < total);
    cnt_after = take ? cnt + 5'd1 : cnt;
    dims_ok   = (m_tok >= 8'd1) && (m_tok <= 8'(MAX_DIM)) &&
                (acc >= 8'd1) && (acc <= 8'(MAX_DIM));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      acc        <= '0;
      m_tok      <= '0;
      have_digit <= 1'b0;
      done_seen  <= 1'b0;
      cnt        <= '0;
      tmo        <= '0;
      wen        <= 1'b0;
      m          <= '0;
      n          <= '0;
      elem_in    <= '0;
      elem_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      err_code   <= '0;
    end else begin
      wen        <= 1'b0;
      elem_valid <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;

      // Storage may finish early, so its completion is remembered from wen onwards.
      if (input_done && (state == ELEMS || state == PAD || state == WAIT_DONE))
        done_seen <= 1'b1;

      if (state == GET_M || state == GET_N || state == ELEMS) begin
        if (is_digit) begin
          acc        <= acc_sat;
          have_digit <= 1'b1;
        end else if (is_sep || is_term) begin
          acc        <= '0;
          have_digit <= 1'b0;
        end
      end

      case (state)
        IDLE: begin
          if (start) begin
            state      <= GET_M;
            busy       <= 1'b1;
            err_code   <= '0;
            done_seen  <= 1'b0;
            acc        <= '0;
            have_digit <= 1'b0;
            tmo        <= '0;
          end
        end
        GET_M: begin
          if (commit) begin
            m     <= acc[3:0];
            m_tok <= acc;
          end
          if (is_term) begin
            err      <= 1'b1;
            err_code <= 2'd1;
            busy     <= 1'b0;
            state    <= IDLE;
          end else if (commit) begin
            state <= GET_N;
          end
        end
        GET_N: begin
          if (commit)
            n <= acc[3:0];
          if (is_term || (commit && !dims_ok)) begin
            err      <= 1'b1;
            err_code <= 2'd1;
            busy     <= 1'b0;
            state    <= IDLE;
          end else if (commit) begin
            wen   <= 1'b1;
            cnt   <= '0;
            state <= ELEMS;
          end
        end
        ELEMS: begin
          if (take) begin
            elem_valid <= 1'b1;
            elem_in    <= ELEM_WIDTH'(acc);
            cnt        <= cnt + 5'd1;
          end
          if (is_term) begin
            tmo   <= '0;
            state <= (cnt_after < total) ? PAD : WAIT_DONE;
          end
        end
        PAD: begin
          if (cnt < total) begin
            elem_valid <= 1'b1;
            elem_in    <= '0;
            cnt        <= cnt + 5'd1;
          end
          if (cnt + 5'd1 >= total)
            state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (done_seen || input_done) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (tmo == TMO_W'(DONE_TIMEOUT - 1)) begin
            err      <= 1'b1;
            err_code <= 2'd3;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_matrix_input_parser.sv
// Scoreboard bench for matrix_input_parser: a string-level reference model predicts
// the storage-side event stream (wen, elements, done/err) for every matrix entry.
module tb_matrix_input_parser;
  localparam int ELEM_WIDTH   = 8;
  localparam int MAX_DIM      = 5;
  localparam int DONE_TIMEOUT = 16;
  localparam int EV_WEN  = 1;
  localparam int EV_ELEM = 2;
  localparam int EV_DONE = 3;
  localparam int EV_ERR  = 4;

  typedef struct packed {
    logic [2:0] kind;
    logic [7:0] a;
    logic [7:0] b;
  } ev_t;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  start = 1'b0;
  logic [7:0]            rx_data = 8'h00;
  logic                  rx_valid = 1'b0;
  logic                  input_done = 1'b0;
  logic                  wen, elem_valid, busy, done, err;
  logic [3:0]            m, n;
  logic [ELEM_WIDTH-1:0] elem_in;
  logic [1:0]            err_code;

  ev_t        exp_q[$];
  logic [7:0] gen_q[$];
  int n_cmp = 0;
  int n_fail = 0;
  int exp_m = 0;
  int exp_n = 0;
  bit hdr_ok;
  int hdr_end;
  int exp_pad;
  int exp_code;

  matrix_input_parser #(
    .ELEM_WIDTH(ELEM_WIDTH), .MAX_DIM(MAX_DIM), .DONE_TIMEOUT(DONE_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .input_done(input_done), .wen(wen), .m(m), .n(n), .elem_in(elem_in),
    .elem_valid(elem_valid), .busy(busy), .done(done), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got running, expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic ev_t mk(input int kind, input int a, input int b);
    ev_t e;
    e.kind = 3'(kind);
    e.a    = 8'(a);
    e.b    = 8'(b);
    return e;
  endfunction

  // Reference model: tokenises the whole entry text and predicts the event sequence.
  function automatic void model(input logic [7:0] s[$], input int dmode);
    int toks[$];
    int cur, mm, nn, total, used;
    bit has, in_hdr, ended, term;
    logic [7:0] c;
    cur = 0; has = 0; in_hdr = 1; ended = 0; mm = 0; nn = 0;
    hdr_ok = 0; hdr_end = -1; exp_pad = 0; exp_code = 1;
    for (int i = 0; i < s.size() && !ended; i++) begin
      c = s[i];
      term = (c == 8'h0D) || (c == 8'h0A);
      if (c >= 8'h30 && c <= 8'h39) begin
        cur = cur * 10 + int'(c - 8'h30);
        if (cur > 255) cur = 255;
        has = 1;
      end else if (c == 8'h20 || c == 8'h2C || term) begin
        if (has) toks.push_back(cur);
        cur = 0;
        has = 0;
        if (in_hdr) begin
          if (term) begin
            exp_q.push_back(mk(EV_ERR, 1, 0));
            ended = 1;
          end else if (toks.size() == 2) begin
            mm = toks[0];
            nn = toks[1];
            toks.delete();
            hdr_end = i;
            if (mm < 1 || mm > MAX_DIM || nn < 1 || nn > MAX_DIM) begin
              exp_q.push_back(mk(EV_ERR, 1, 0));
              ended = 1;
            end else begin
              exp_q.push_back(mk(EV_WEN, mm, nn));
              in_hdr = 0;
              hdr_ok = 1;
            end
          end
        end else if (term) begin
          ended = 1;
        end
      end
    end
    if (hdr_ok) begin
      total = mm * nn;
      used  = (toks.size() < total) ? toks.size() : total;
      for (int e = 0; e < total; e++)
        exp_q.push_back(mk(EV_ELEM, (e < toks.size()) ? toks[e] : 0, 0));
      exp_pad = total - used;
      if (dmode == 2) begin
        exp_q.push_back(mk(EV_ERR, 3, 0));
        exp_code = 3;
      end else begin
        exp_q.push_back(mk(EV_DONE, 0, 0));
        exp_code = 0;
      end
    end
  endfunction

  task automatic popCheck(input int kind, input int a, input int b);
    ev_t e;
    checkOutput("event_expected", int'(exp_q.size() > 0), 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput("event_kind", kind, int'(e.kind));
      if (kind == int'(e.kind)) begin
        case (kind)
          EV_WEN: begin
            checkOutput("wen_m", a, int'(e.a));
            checkOutput("wen_n", b, int'(e.b));
            exp_m = int'(e.a);
            exp_n = int'(e.b);
          end
          EV_ELEM: checkOutput("elem_in", a, int'(e.a));
          EV_ERR:  checkOutput("err_code", a, int'(e.a));
          default: checkOutput("done_busy", a, 0);
        endcase
      end
    end
  endtask

  // Monitor: every output pulse is matched against the head of the expected queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (wen || elem_valid)
        checkOutput("wen_elem_exclusive", int'(wen && elem_valid), 0);
      if (wen) popCheck(EV_WEN, int'(m), int'(n));
      if (elem_valid) begin
        popCheck(EV_ELEM, int'(elem_in), 0);
        checkOutput("elem_m_stable", int'(m), exp_m);
        checkOutput("elem_n_stable", int'(n), exp_n);
      end
      if (done) popCheck(EV_DONE, int'(busy), 0);
      if (err) begin
        popCheck(EV_ERR, int'(err_code), 0);
        checkOutput("err_busy", int'(busy), 0);
      end
    end
  end

  task automatic sendByte(input logic [7:0] b, input bit with_done, input bit with_start);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    @(negedge clk);
    rx_data    = b;
    rx_valid   = 1'b1;
    input_done = with_done;
    start      = with_start;
    @(negedge clk);
    rx_valid   = 1'b0;
    input_done = 1'b0;
    start      = 1'b0;
    rx_data    = 8'($urandom);
  endtask

  task automatic pulseStart();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic applyStimulus(input logic [7:0] s[$], input int dmode, input bit poke);
    bit wd, ws;
    int k, t;
    model(s, dmode);
    pulseStart();
    for (int i = 0; i < s.size(); i++) begin
      wd = (dmode == 1) && hdr_ok && (i == hdr_end + 1);
      ws = poke && hdr_ok && (i > hdr_end) && (i < s.size() - 1) && ($urandom_range(0, 3) == 0);
      sendByte(s[i], wd, ws);
    end
    if (hdr_ok && dmode == 0) begin
      repeat (3) @(negedge clk);
      input_done = 1'b1;
      @(negedge clk);
      input_done = 1'b0;
    end
    if (hdr_ok && dmode == 2) begin
      for (k = 1; k <= 100; k++) begin
        @(posedge clk);
        #1;
        if (err) break;
      end
      checkOutput("timeout_latency", k, DONE_TIMEOUT + exp_pad);
    end
    for (t = 0; t < 300; t++) begin
      if (!busy) break;
      @(negedge clk);
    end
    checkOutput("session_ends", int'(t < 300), 1);
    repeat (2) @(negedge clk);
    checkOutput("queue_drained", exp_q.size(), 0);
    checkOutput("idle_busy", int'(busy), 0);
    checkOutput("err_code_held", int'(err_code), exp_code);
    exp_q.delete();
  endtask

  // '~' stands for CR and '|' for LF in directed entry text.
  task automatic runText(input string txt, input int dmode, input bit poke);
    logic [7:0] s[$];
    logic [7:0] c;
    for (int i = 0; i < txt.len(); i++) begin
      c = txt[i];
      if (c == 8'h7E) c = 8'h0D;
      else if (c == 8'h7C) c = 8'h0A;
      s.push_back(c);
    end
    applyStimulus(s, dmode, poke);
  endtask

  task automatic pushNum(input int v);
    string d;
    d = $sformatf("%0d", v);
    for (int i = 0; i < d.len(); i++) begin
      gen_q.push_back(d[i]);
      if (i < d.len() - 1 && $urandom_range(0, 9) == 0) gen_q.push_back(8'h78);
    end
  endtask

  task automatic pushSep();
    gen_q.push_back(($urandom_range(0, 1) == 1) ? 8'h2C : 8'h20);
    if ($urandom_range(0, 5) == 0) gen_q.push_back(8'h20);
  endtask

  function automatic int pickDim();
    if ($urandom_range(0, 9) == 0)
      return ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(6, 12));
    return int'($urandom_range(1, MAX_DIM));
  endfunction

  task automatic genSession();
    int mm, nn, k, v;
    gen_q.delete();
    mm = pickDim();
    nn = pickDim();
    if ($urandom_range(0, 14) == 0) begin
      pushNum(mm);
      gen_q.push_back(8'h0D);
      return;
    end
    pushNum(mm); pushSep(); pushNum(nn); pushSep();
    if (mm >= 1 && mm <= MAX_DIM && nn >= 1 && nn <= MAX_DIM)
      k = int'($urandom_range(0, mm * nn + 2));
    else
      k = int'($urandom_range(0, 3));
    for (int j = 0; j < k; j++) begin
      v = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 999)) : int'($urandom_range(0, 255));
      pushNum(v);
      if (j < k - 1 || $urandom_range(0, 1) == 0) pushSep();
    end
    gen_q.push_back(($urandom_range(0, 1) == 1) ? 8'h0D : 8'h0A);
  endtask

  initial begin
    string pre;
    repeat (3) @(negedge clk);
    checkOutput("reset_wen", int'(wen), 0);
    checkOutput("reset_m", int'(m), 0);
    checkOutput("reset_n", int'(n), 0);
    checkOutput("reset_elem_in", int'(elem_in), 0);
    checkOutput("reset_elem_valid", int'(elem_valid), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(done), 0);
    checkOutput("reset_err", int'(err), 0);
    checkOutput("reset_err_code", int'(err_code), 0);
    rst = 1'b0;

    pre = "5 5 1\r";
    for (int i = 0; i < pre.len(); i++) sendByte(pre[i], 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    checkOutput("idle_ignores_rx", int'(busy), 0);

    runText("2 2 1 2 3 4~", 0, 1'b1);
    runText("2 3 7 8|", 0, 1'b0);
    runText("1 2 5 6 9 9~", 0, 1'b0);
    runText("6 2~", 0, 1'b0);
    runText("3~", 0, 1'b0);
    runText("1 1 300,~", 2, 1'b0);
    runText("2 2 1 2 3 4~", 1, 1'b0);

    // Reset in the middle of an entry, after two elements have gone out.
    exp_q.push_back(mk(EV_WEN, 2, 2));
    exp_q.push_back(mk(EV_ELEM, 1, 0));
    exp_q.push_back(mk(EV_ELEM, 2, 0));
    pulseStart();
    pre = "2 2 1 2 ";
    for (int i = 0; i < pre.len(); i++) sendByte(pre[i], 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("rst_pre_queue", exp_q.size(), 0);
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst_wen", int'(wen), 0);
    checkOutput("midrst_m", int'(m), 0);
    checkOutput("midrst_n", int'(n), 0);
    checkOutput("midrst_elem_in", int'(elem_in), 0);
    checkOutput("midrst_elem_valid", int'(elem_valid), 0);
    checkOutput("midrst_busy", int'(busy), 0);
    checkOutput("midrst_done", int'(done), 0);
    checkOutput("midrst_err", int'(err), 0);
    checkOutput("midrst_err_code", int'(err_code), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("post_rst_idle", int'(busy), 0);
    runText("2 2 4 3 2 1~", 0, 1'b0);

    for (int s = 0; s < 40; s++) begin
      genSession();
      applyStimulus(gen_q, int'($urandom_range(0, 2)), $urandom_range(0, 1) == 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
